// File: rtl/display_pkg.sv
// Shared types and helpers for the multiplexed digit display scanner.
package display_pkg;

  typedef enum logic {
    S_BLANK = 1'b0,
    S_DRIVE = 1'b1
  } state_t;

  localparam logic [3:0] BCD_MAX    = 4'd9;
  localparam int         MAX_DIGITS = 8;
  localparam int         VEC_W      = 4 * MAX_DIGITS;

  // Anode pattern with every digit dark; common-anode parts are active-low.
  function automatic logic [MAX_DIGITS-1:0] anode_all_off(input logic led_type_ctl,
                                                          input int   width);
    logic [MAX_DIGITS-1:0] pattern;
    pattern = '0;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (i < width) pattern[i] = led_type_ctl;
    end
    return pattern;
  endfunction

  function automatic logic [3:0] digit_at(input logic [VEC_W-1:0] vec, input int k);
    return vec[4*k +: 4];
  endfunction

endpackage

// File: rtl/display_scan_ctrl_scan_slot_timer.sv
// Slot timer: counts cycles within the current BLANK or DRIVE slot and flags the last one.
module scan_slot_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [CNT_W-1:0] len_m1,
  output logic             done
);

  logic [CNT_W-1:0] cnt;

  assign done = (cnt == len_m1);

  // Every state change coincides with done, so clearing on done restarts each slot at 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (done) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed BCD display scanner with frame double-buffering and inter-digit blanking.
// Optional leading-zero suppression is enabled by defining DISPLAY_LZ_BLANK_EN.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int DRIVE_CYCLES = 50000,
  parameter int BLANK_CYCLES = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic                    load,
  input  logic                    led_type_ctl,
  output logic [3:0]              b_coded_dgt,
  output logic [NUM_DIGITS-1:0]   anode_en,
  output logic                    frame_start,
  output logic                    invalid_digit
);

  localparam int MAX_LEN = (DRIVE_CYCLES > BLANK_CYCLES) ? DRIVE_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int IDX_W   = $clog2(NUM_DIGITS);

  localparam logic [CNT_W-1:0] DRIVE_M1 = CNT_W'(DRIVE_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_M1 = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  state_t                  state;
  logic [IDX_W-1:0]        idx;
  logic [IDX_W-1:0]        idx_next;
  logic [4*NUM_DIGITS-1:0] shadow;
  logic [4*NUM_DIGITS-1:0] frame;
  logic [4*NUM_DIGITS-1:0] frame_next;
  logic [NUM_DIGITS-1:0]   onehot;
  logic [CNT_W-1:0]        len_m1;
  logic [3:0]              cur_dgt;
  logic                    done;
  logic                    wrap;
  logic                    lit;
  logic                    lz_suppress;

  assign len_m1 = (state == S_DRIVE) ? DRIVE_M1 : BLANK_M1;

  scan_slot_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .len_m1  (len_m1),
    .done    (done)
  );

  assign wrap       = (idx == LAST_IDX);
  assign idx_next   = wrap ? '0 : idx + IDX_W'(1);
  // A load landing on the wrap edge is newer than the shadow copy.
  assign frame_next = wrap ? (load ? bcd_in : shadow) : frame;
  assign cur_dgt    = digit_at(VEC_W'(frame), int'(idx));

`ifdef DISPLAY_LZ_BLANK_EN
  always_comb begin
    lz_suppress = (idx != '0);
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (k >= int'(idx) && digit_at(VEC_W'(frame), k) != 4'd0) lz_suppress = 1'b0;
    end
  end
`else
  assign lz_suppress = 1'b0;
`endif

  assign lit = (cur_dgt <= BCD_MAX) && !lz_suppress;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_BLANK;
      idx           <= '0;
      shadow        <= '0;
      frame         <= '0;
      onehot        <= '0;
      b_coded_dgt   <= 4'd0;
      frame_start   <= 1'b0;
      invalid_digit <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (load) shadow <= bcd_in;
      if (done) begin
        if (state == S_BLANK) begin
          state         <= S_DRIVE;
          onehot        <= lit ? (NUM_DIGITS'(1) << idx) : '0;
          invalid_digit <= (cur_dgt > BCD_MAX);
        end else begin
          // Next code is presented now so the decoder settles during blanking.
          state         <= S_BLANK;
          onehot        <= '0;
          invalid_digit <= 1'b0;
          idx           <= idx_next;
          b_coded_dgt   <= digit_at(VEC_W'(frame_next), int'(idx_next));
          if (wrap) begin
            frame       <= frame_next;
            frame_start <= 1'b1;
          end
        end
      end
    end
  end

  assign anode_en = NUM_DIGITS'(anode_all_off(led_type_ctl, NUM_DIGITS)) ^ onehot;

endmodule

// File: doc/display_scan_ctrl.md
Name: display_scan_ctrl

Overview:
- Time-multiplexes NUM_DIGITS BCD digits onto one shared LED_Decoder instance and one segment bus; drives per-digit anode enables.
- Sits between the BCD counter (digit source) and the decoder/display pins.
- Double-buffers digit values so a frame never tears, and inserts blanking dead time between digits to suppress ghosting.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (2..8).
- DRIVE_CYCLES, 50000, clk cycles each digit is lit per slot (>=1).
- BLANK_CYCLES, 8, clk cycles all anodes are off between slots (>=1).

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- bcd_in  in  4*NUM_DIGITS  digit values; digit k = bcd_in[4k+3:4k], digit 0 = rightmost.
- load  in  1  single-cycle strobe; captures bcd_in into the shadow register.
- led_type_ctl  in  1  1 = common-anode (anodes active-low); 0 = common-cathode (anodes active-high). Same meaning as the decoder input of the same name.
- b_coded_dgt  out  4  digit code to the shared decoder.
- anode_en  out  NUM_DIGITS  one-hot digit enable; polarity set by led_type_ctl.
- frame_start  out  1  one-cycle pulse when the slot index wraps to 0.
- invalid_digit  out  1  high for the whole DRIVE slot of a digit whose value is >9.

Behaviour:
- Reset (async assert, sync release): state=S_BLANK, cnt=0, idx=0, shadow=0, frame=0, b_coded_dgt=0, frame_start=0, invalid_digit=0, anode_en=all-off.
  - All-off is all-ones if led_type_ctl=1, all-zeros if led_type_ctl=0.
  - anode_en polarity is applied combinationally from the registered one-hot, so it tracks led_type_ctl with no latency.
- Counters: cnt is wide enough for max(DRIVE_CYCLES, BLANK_CYCLES)-1. It clears on every state change.
- FSM, two states:
  - S_BLANK: anodes all off; b_coded_dgt already holds frame[idx].
    - When cnt==BLANK_CYCLES-1, go to S_DRIVE.
  - S_DRIVE: anode idx on, unless frame[idx]>9; in that case anodes stay off and invalid_digit=1.
    - When cnt==DRIVE_CYCLES-1, go to S_BLANK and set idx=(idx+1) mod NUM_DIGITS.
    - b_coded_dgt updates to the new frame[idx] on the same edge, so the decoder settles during blanking.
- Wrap: on the DRIVE→BLANK edge where idx goes from NUM_DIGITS-1 to 0:
  - frame <= load ? bcd_in : shadow (a same-cycle load wins);
  - frame_start pulses for 1 cycle.
- load: shadow <= bcd_in on any cycle; a later load in the same frame overwrites an earlier one. The frame register changes only at the wrap.
- Frame period: NUM_DIGITS*(DRIVE_CYCLES+BLANK_CYCLES) cycles. The first S_DRIVE begins BLANK_CYCLES cycles after reset release.
- Changing led_type_ctl mid-slot flips anode polarity immediately; sequencing is unaffected.
- Reset mid-slot: every register returns to its reset value at once; no partial slot completes.

Optional Feature:
- Macro: DISPLAY_LZ_BLANK_EN.
- Defined: leading-zero suppression. In S_DRIVE, digit idx keeps its anode off if idx>0, frame[idx]==0, and every frame digit above idx is 0.
  - Digit 0 is always shown.
  - A suppressed zero does not assert invalid_digit.
- Undefined: every valid digit is lit, including leading zeros.

Decomposition:
- Package display_pkg:
  - state enum {S_BLANK, S_DRIVE};
  - BCD_MAX=4'd9;
  - a function that builds the all-off anode pattern from led_type_ctl and width;
  - a function that extracts digit k from a packed vector.
- One natural sub-module: scan_slot_timer, holding cnt and terminal-count compare with DRIVE/BLANK lengths as inputs.
- The decoder itself is instantiated by the parent, not inside this block.

Test Plan (NUM_DIGITS=4, DRIVE_CYCLES=5, BLANK_CYCLES=2 unless stated):
1. Reset, then load bcd_in=16'h4321 once with led_type_ctl=0.
   - Second frame shows b_coded_dgt 1,2,3,4 with anode_en 0001,0010,0100,1000.
   - Each digit is lit 5 cycles, with 2 all-zero cycles between digits.
   - frame_start pulses every 28 cycles.
2. Same stimulus with led_type_ctl=1 -> anode_en 1110,1101,1011,0111 while lit, 1111 during blanking.
3. Load 16'h1111 mid-frame, then 16'h2222 two cycles later -> current frame unchanged; next frame shows all 2s.
4. Load asserted with bcd_in=16'h9999 exactly on the wrap edge -> next frame shows 9s (not the old shadow).
5. Load 16'h00A5 -> during digit 1's slot (value A) anodes stay off and invalid_digit=1 for 5 cycles; other digits behave normally.
6. Assert reset_n low mid-DRIVE -> anode_en goes to all-off and b_coded_dgt to 0 asynchronously. With DISPLAY_LZ_BLANK_EN and load 16'h0070, only digits 0 and 1 light.
